// File: rtl/arm_defs_pkg.sv
// Shared types and constants for the write-back stage.
package arm_defs_pkg;

    localparam int DATA_W   = 32;
    localparam int REG_AW   = 4;
    localparam int NUM_REGS = 15;

    localparam logic [REG_AW-1:0] REG_PC = 4'd15;

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic              mem_read;
        logic [DATA_W-1:0] alu_result;
    } wb_entry_t;

    // R15 (PC) has no bit in the mask, so it decodes to all zeros.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] r);
        logic [NUM_REGS-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            m[i] = (r == REG_AW'(i));
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of pending write-back entries, with a per-slot
// valid/dest view so the top level can build the hazard busy mask.
module wb_fifo
    import arm_defs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  wb_entry_t                 push_entry,
    input  logic                      pop,
    output wb_entry_t                 head,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      empty,
    output logic [DEPTH-1:0]          entry_vld,
    output logic [DEPTH*REG_AW-1:0]   entry_dest
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    always_comb begin
        logic [PW-1:0] age;
        entry_vld  = '0;
        entry_dest = '0;
        for (int i = 0; i < DEPTH; i++) begin
            age = PW'(i) - rd_ptr;
            entry_vld[i] = ({1'b0, age} < count);
            entry_dest[i*REG_AW +: REG_AW] = mem[i].dest;
        end
    end

endmodule

// File: rtl/write_back_unit.sv
// WB-stage register-file writer: in-order queue, load-data merge, one retire per cycle.
// Define WB_BYPASS_EN to let a retirable entry skip an empty queue (1-edge latency).
module write_back_unit
    import arm_defs_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_wb_en,
    input  logic                in_mem_read,
    input  logic [REG_AW-1:0]   in_dest,
    input  logic [DATA_W-1:0]   in_alu_result,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_data,
    output logic                write_back_en,
    output logic [REG_AW-1:0]   dest_wb,
    output logic [DATA_W-1:0]   result_wb,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                rsp_err
);

    localparam int CW = $clog2(DEPTH) + 1;

    wb_entry_t               push_entry;
    wb_entry_t               head;
    logic [CW-1:0]           fifo_count;
    logic                    fifo_empty;
    logic [DEPTH-1:0]        entry_vld;
    logic [DEPTH*REG_AW-1:0] entry_dest;

    logic accept;
    logic in_write;
    logic head_retire;
    logic byp_vld_p0;
    logic push;
    logic rsp_used;

    assign in_ready    = (fifo_count < CW'(DEPTH));
    assign accept      = in_valid & in_ready;
    assign in_write    = accept & in_wb_en & (in_dest != REG_PC);
    assign head_retire = ~fifo_empty & (~head.mem_read | mem_rsp_valid);

`ifdef WB_BYPASS_EN
    assign byp_vld_p0  = in_write & fifo_empty & (~in_mem_read | mem_rsp_valid);
`else
    assign byp_vld_p0  = 1'b0;
`endif

    assign push        = in_write & ~byp_vld_p0;
    assign rsp_used    = (head_retire & head.mem_read) | (byp_vld_p0 & in_mem_read);
    assign push_entry  = '{dest: in_dest, mem_read: in_mem_read, alu_result: in_alu_result};

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (head_retire),
        .head       (head),
        .count      (fifo_count),
        .empty      (fifo_empty),
        .entry_vld  (entry_vld),
        .entry_dest (entry_dest)
    );

    // Write-port stage: registered so the negedge register-file write sees stable values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_back_en <= 1'b0;
            dest_wb       <= '0;
            result_wb     <= '0;
            rsp_err       <= 1'b0;
        end else begin
            if (head_retire) begin
                write_back_en <= 1'b1;
                dest_wb       <= head.dest;
                result_wb     <= head.mem_read ? mem_rsp_data : head.alu_result;
            end else if (byp_vld_p0) begin
                write_back_en <= 1'b1;
                dest_wb       <= in_dest;
                result_wb     <= in_mem_read ? mem_rsp_data : in_alu_result;
            end else begin
                write_back_en <= 1'b0;
            end
            if (mem_rsp_valid & ~rsp_used) rsp_err <= 1'b1;
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i]) busy_mask = busy_mask | reg_onehot(entry_dest[i*REG_AW +: REG_AW]);
        end
        if (write_back_en) busy_mask = busy_mask | reg_onehot(dest_wb);
    end

endmodule
